// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared types, constants and arbitration helper for the intersection blocks
package traffic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GNT_NS = 2'd1,
        ST_GNT_EW = 2'd2,
        ST_CLEAR  = 2'd3
    } state_t;

    localparam logic DIR_NS = 1'b0;
    localparam logic DIR_EW = 1'b1;

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;

    localparam int DEF_CW        = 8;
    localparam int DEF_DEBOUNCE  = 3;
    localparam int DEF_MINGRANT  = 10;
    localparam int DEF_MAXGRANT  = 60;
    localparam int DEF_CLEARTIME = 3;

    typedef struct packed {
        logic grant;
        logic dir;
    } arb_t;

    // Round-robin: a tie goes to the direction that was not granted last.
    function automatic arb_t arbitrate(input logic valid_ns, input logic valid_ew,
                                       input logic last_grant);
        arb_t r;
        r.grant = valid_ns | valid_ew;
        if (valid_ns && valid_ew) begin
            r.dir = ~last_grant;
        end else if (valid_ns) begin
            r.dir = DIR_NS;
        end else begin
            r.dir = DIR_EW;
        end
        return r;
    endfunction

endpackage

// File: rtl/emg_req_filter.sv
// rtl/emg_req_filter.sv - two-flop synchroniser plus saturating debounce for one request
//
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   req        : raw asynchronous request
//   sync       : synchronised request (second flop)
//   ok         : synchronised request has been high DEBOUNCE consecutive cycles
module emg_req_filter #(
    parameter int CW       = 8,
    parameter int DEBOUNCE = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    output logic sync,
    output logic ok
);

    logic          meta;
    logic          sync_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta   <= 1'b0;
            sync_q <= 1'b0;
            cnt    <= '0;
        end else begin
            meta   <= req;
            sync_q <= meta;
            if (!sync_q) begin
                cnt <= '0;
            end else if (cnt != CW'(DEBOUNCE)) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign sync = sync_q;
    assign ok   = (cnt == CW'(DEBOUNCE));

endmodule

// File: rtl/emg_preempt_arbiter.sv
// rtl/emg_preempt_arbiter.sv - emergency preemption arbiter with min/max grant and all-red clearance
//
// Ports:
//   clk, rst_n         : clock, synchronous active-low reset
//   req_n_s, req_e_w   : raw emergency requests (asynchronous)
//   emg_n_s, emg_e_w   : mutually exclusive preemption outputs
//   clr_active         : all-red clearance interval in progress
//   lock_n_s, lock_e_w : direction timed out, locked until its request drops
//   busy               : arbiter not idle
module emg_preempt_arbiter
    import traffic_pkg::*;
#(
    parameter int CW        = DEF_CW,
    parameter int DEBOUNCE  = DEF_DEBOUNCE,
    parameter int MINGRANT  = DEF_MINGRANT,
    parameter int MAXGRANT  = DEF_MAXGRANT,
    parameter int CLEARTIME = DEF_CLEARTIME
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_n_s,
    input  logic req_e_w,
    output logic emg_n_s,
    output logic emg_e_w,
    output logic clr_active,
    output logic lock_n_s,
    output logic lock_e_w,
    output logic busy
);

    state_t        state;
    logic [CW-1:0] timer;
    logic          last_grant;
    logic          lock_ns_q;
    logic          lock_ew_q;

    logic sync_ns, sync_ew;
    logic ok_ns, ok_ew;

    emg_req_filter #(.CW(CW), .DEBOUNCE(DEBOUNCE)) u_filt_ns (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req_n_s),
        .sync  (sync_ns),
        .ok    (ok_ns)
    );

    emg_req_filter #(.CW(CW), .DEBOUNCE(DEBOUNCE)) u_filt_ew (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req_e_w),
        .sync  (sync_ew),
        .ok    (ok_ew)
    );

    logic          valid_ns, valid_ew;
    arb_t          arb;
    logic          min_hit, max_hit, clr_done;
    logic          rel_ns, rel_ew;
    logic          set_lock_ns, set_lock_ew;
    logic [CW-1:0] timer_inc;
    state_t        grant_state;

    assign valid_ns    = ok_ns & ~lock_ns_q;
    assign valid_ew    = ok_ew & ~lock_ew_q;
    assign arb         = arbitrate(valid_ns, valid_ew, last_grant);
    assign grant_state = (arb.dir == DIR_NS) ? ST_GNT_NS : ST_GNT_EW;

    assign min_hit  = (timer >= CW'(MINGRANT - 1));
    assign max_hit  = (timer >= CW'(MAXGRANT - 1));
    assign clr_done = (timer == CW'(CLEARTIME - 1));

    // A request that drops only ends the grant once the minimum time is served;
    // the timeout ends it regardless.
    assign rel_ns = (min_hit & ~ok_ns) | max_hit;
    assign rel_ew = (min_hit & ~ok_ew) | max_hit;

    assign set_lock_ns = (state == ST_GNT_NS) & max_hit;
    assign set_lock_ew = (state == ST_GNT_EW) & max_hit;

    assign timer_inc = (timer == '1) ? timer : timer + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            timer      <= '0;
            last_grant <= DIR_EW;
            lock_ns_q  <= 1'b0;
            lock_ew_q  <= 1'b0;
        end else begin
            // Dropping the request releases the lock, even on a timeout edge.
            if (!sync_ns) begin
                lock_ns_q <= 1'b0;
            end else if (set_lock_ns) begin
                lock_ns_q <= 1'b1;
            end
            if (!sync_ew) begin
                lock_ew_q <= 1'b0;
            end else if (set_lock_ew) begin
                lock_ew_q <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (arb.grant) begin
                        state      <= grant_state;
                        last_grant <= arb.dir;
                        timer      <= '0;
                    end else begin
                        timer <= timer_inc;
                    end
                end
                ST_GNT_NS: begin
                    if (rel_ns) begin
                        state <= ST_CLEAR;
                        timer <= '0;
                    end else begin
                        timer <= timer_inc;
                    end
                end
                ST_GNT_EW: begin
                    if (rel_ew) begin
                        state <= ST_CLEAR;
                        timer <= '0;
                    end else begin
                        timer <= timer_inc;
                    end
                end
                ST_CLEAR: begin
                    if (clr_done) begin
                        timer <= '0;
                        if (arb.grant) begin
                            state      <= grant_state;
                            last_grant <= arb.dir;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        timer <= timer_inc;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    timer <= '0;
                end
            endcase
        end
    end

    assign emg_n_s    = (state == ST_GNT_NS);
    assign emg_e_w    = (state == ST_GNT_EW);
    assign clr_active = (state == ST_CLEAR);
    assign busy       = (state != ST_IDLE);
    assign lock_n_s   = lock_ns_q;
    assign lock_e_w   = lock_ew_q;

endmodule

// File: tb/tb_emg_preempt_arbiter.sv
// tb/tb_emg_preempt_arbiter.sv - self-checking bench for emg_preempt_arbiter
module tb_emg_preempt_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    logic req_n_s, req_e_w;
    logic emg_n_s, emg_e_w, clr_active, lock_n_s, lock_e_w, busy;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    emg_preempt_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_n_s    (req_n_s),
        .req_e_w    (req_e_w),
        .emg_n_s    (emg_n_s),
        .emg_e_w    (emg_e_w),
        .clr_active (clr_active),
        .lock_n_s   (lock_n_s),
        .lock_e_w   (lock_e_w),
        .busy       (busy)
    );

    // dir: 0 = N-S, 1 = E-W. len = number of edges sampling the request high.
    // exp_rise = edge index of first grant (0 = never).
    typedef struct {
        logic dir;
        int   len;
        int   exp_rise;
        int   exp_high;
        int   exp_clr;
        logic exp_lock;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic dir, input logic v);
        if (dir) req_e_w = v;
        else     req_n_s = v;
    endtask

    task automatic run_vec(input int i);
        int rise, high, other, clr;
        logic lockv;
        rise = 0; high = 0; other = 0; clr = 0; lockv = 1'b0;
        set_req(vecs[i].dir, 1'b1);
        for (int k = 1; k <= vecs[i].len + 25; k++) begin
            step();
            if (vecs[i].dir ? emg_e_w : emg_n_s) begin
                if (rise == 0) rise = k;
                high++;
            end
            if (vecs[i].dir ? emg_n_s : emg_e_w) other++;
            if (clr_active) clr++;
            if (k == vecs[i].len) begin
                lockv = vecs[i].dir ? lock_e_w : lock_n_s;
                set_req(vecs[i].dir, 1'b0);
            end
        end
        check($sformatf("v%0d rise_edge", i), rise, vecs[i].exp_rise);
        check($sformatf("v%0d high_cycles", i), high, vecs[i].exp_high);
        check($sformatf("v%0d other_dir_high", i), other, 0);
        check($sformatf("v%0d clr_cycles", i), clr, vecs[i].exp_clr);
        check($sformatf("v%0d lock_at_end_of_req", i), int'(lockv), int'(vecs[i].exp_lock));
        for (int k = 0; k < 6; k++) step();
        check($sformatf("v%0d busy_after", i), int'(busy), 0);
    endtask

    initial begin
        int ns_rise, ns_high, ew_rise, ew_high, clr, both;
        int rise;

        vecs[0] = '{1'b0,  2, 0,  0, 0, 1'b0};
        vecs[1] = '{1'b1,  2, 0,  0, 0, 1'b0};
        vecs[2] = '{1'b0, 30, 6, 28, 3, 1'b0};
        vecs[3] = '{1'b0,  5, 6, 10, 3, 1'b0};
        vecs[4] = '{1'b1, 30, 6, 28, 3, 1'b0};
        vecs[5] = '{1'b1, 70, 6, 60, 3, 1'b1};
        vecs[6] = '{1'b1,  5, 6, 10, 3, 1'b0};

        // Reset with both requests high: everything low.
        rst_n = 1'b0; req_n_s = 1'b1; req_e_w = 1'b1;
        step();
        step();
        check("reset_outputs", int'({emg_n_s, emg_e_w, clr_active, lock_n_s, lock_e_w, busy}), 0);
        rst_n = 1'b1;

        // Tie after reset: N-S first, 3-cycle gap, then E-W.
        ns_rise = 0; ns_high = 0; ew_rise = 0; ew_high = 0; clr = 0; both = 0;
        for (int k = 1; k <= 50; k++) begin
            step();
            if (emg_n_s) begin
                if (ns_rise == 0) ns_rise = k;
                ns_high++;
            end
            if (emg_e_w) begin
                if (ew_rise == 0) ew_rise = k;
                ew_high++;
            end
            if (clr_active) clr++;
            if (emg_n_s && emg_e_w) both++;
            if (k == 15) req_n_s = 1'b0;
            if (k == 40) req_e_w = 1'b0;
        end
        check("tie_ns_rise", ns_rise, 6);
        check("tie_ns_high", ns_high, 13);
        check("tie_ew_rise", ew_rise, 22);
        check("tie_ew_high", ew_high, 22);
        check("tie_clr_cycles", clr, 6);
        check("tie_both_high", both, 0);
        for (int k = 0; k < 6; k++) step();

        // Reset in the middle of a grant drops the output immediately.
        req_n_s = 1'b1;
        for (int k = 0; k < 8; k++) step();
        check("midgrant_ns_high", int'(emg_n_s), 1);
        rst_n = 1'b0;
        step();
        check("midgrant_reset_outputs",
              int'({emg_n_s, emg_e_w, clr_active, lock_n_s, lock_e_w, busy}), 0);
        rst_n = 1'b1;
        req_n_s = 1'b0;
        for (int k = 0; k < 6; k++) step();

        for (int i = 0; i < 7; i++) run_vec(i);

        // Timeout lock, then drop and re-raise.
        req_e_w = 1'b1;
        ew_high = 0;
        for (int k = 1; k <= 100; k++) begin
            step();
            if (emg_e_w) ew_high++;
        end
        check("lock_ew_high", ew_high, 60);
        check("lock_ew_set", int'(lock_e_w), 1);
        check("lock_busy_idle", int'(busy), 0);
        req_e_w = 1'b0;
        step();
        step();
        check("lock_ew_held_during_sync", int'(lock_e_w), 1);
        step();
        check("lock_ew_cleared", int'(lock_e_w), 0);
        req_e_w = 1'b1;
        rise = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (emg_e_w && rise == 0) rise = k;
        end
        check("lock_regrant_rise", rise, 6);
        req_e_w = 1'b0;
        for (int k = 0; k < 30; k++) step();
        check("final_busy", int'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
